// File: rtl/nios_cpu_debug_cmd_sysclk.sv
// System-clock side command engine for the Nios II JTAG debug slave.
// Brings the tck-domain update-DR / update-IR strobes into clk, captures
// {ir_in, sr} on each update-DR, queues the commands in a small FIFO and
// hands them to the CPU debug logic with a valid/ready handshake. Every
// accepted command is decoded into a one-cycle one-hot action strobe.
module nios_cpu_debug_cmd_sysclk #(
    parameter int SR_W        = 38,
    parameter int IR_W        = 2,
    parameter int ACT_BIT     = 34,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [SR_W-1:0]                 sr,
    input  logic [IR_W-1:0]                 ir_in,
    input  logic                            vs_udr,
    input  logic                            vs_uir,
    input  logic                            cmd_ready,
    input  logic                            ovf_clr,
    output logic [SR_W-1:0]                 jdo,
    output logic [IR_W-1:0]                 cmd_ir,
    output logic                            cmd_valid,
    output logic [(2**IR_W)-1:0]            take_action,
    output logic [(2**IR_W)-1:0]            take_no_action,
    output logic                            ir_update,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow
);

    localparam int NUM_CMD = 2 ** IR_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENT_W   = IR_W + SR_W;

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    // Decode a command index into its one-hot strobe position.
    function automatic logic [NUM_CMD-1:0] onehot(input logic [IR_W-1:0] idx);
        logic [NUM_CMD-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Stage p0: synchroniser chains (index 0 is the metastable flop)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] udr_sync_p0;
    logic [SYNC_STAGES-1:0] uir_sync_p0;

    // Shift the raw tck-domain levels through the synchroniser flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_sync_p0 <= '0;
            uir_sync_p0 <= '0;
        end else begin
            udr_sync_p0 <= {udr_sync_p0[SYNC_STAGES-2:0], vs_udr};
            uir_sync_p0 <= {uir_sync_p0[SYNC_STAGES-2:0], vs_uir};
        end
    end

    // ------------------------------------------------------------------
    // Stage p1: registered rising-edge detectors
    // ------------------------------------------------------------------
    logic udr_prev_p1;
    logic uir_prev_p1;
    logic udr_vld_p1;

    // Registered rise detection; prev resets low so a level held high
    // across reset release still produces exactly one rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_prev_p1 <= 1'b0;
            uir_prev_p1 <= 1'b0;
            udr_vld_p1  <= 1'b0;
            ir_update   <= 1'b0;
        end else begin
            udr_prev_p1 <= udr_sync_p0[SYNC_STAGES-1];
            uir_prev_p1 <= uir_sync_p0[SYNC_STAGES-1];
            udr_vld_p1  <= udr_sync_p0[SYNC_STAGES-1] & ~udr_prev_p1;
            ir_update   <= uir_sync_p0[SYNC_STAGES-1] & ~uir_prev_p1;
        end
    end

    // ------------------------------------------------------------------
    // Stage p2: command FIFO, head registers and decode strobes
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [LVL_W-1:0] level;
    logic [ENT_W-1:0] entry_in;
    logic [ENT_W-1:0] head_nxt;
    logic             head_load;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             drop;

    // sr / ir_in are quasi-static while vs_udr is high, so they are
    // sampled directly once the synchronised rise has been seen.
    assign entry_in   = {ir_in, sr};
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == FULL_LVL);
    assign push       = udr_vld_p1;
    assign pop        = ~fifo_empty & cmd_ready;
    // A pop frees the slot the incoming push lands in, so full+pop+push is legal.
    assign wr_en      = push & (~fifo_full | pop);
    assign drop       = push & fifo_full & ~pop;
    assign rd_next    = rd_ptr + ONE_PTR;

    assign cmd_valid  = ~fifo_empty;
    assign fifo_level = level;

    // Storage array; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({wr_en, pop})
                2'b10:   level <= level + ONE_LVL;
                2'b01:   level <= level - ONE_LVL;
                default: level <= level;
            endcase
        end
    end

    // Pick the next head value: the following stored entry on a pop, the
    // incoming entry when it becomes the only one, otherwise hold.
    always_comb begin
        head_nxt  = {cmd_ir, jdo};
        head_load = 1'b0;
        if (pop) begin
            if (level > ONE_LVL) begin
                head_nxt  = mem[rd_next];
                head_load = 1'b1;
            end else if (wr_en) begin
                head_nxt  = entry_in;
                head_load = 1'b1;
            end
        end else if (wr_en && fifo_empty) begin
            head_nxt  = entry_in;
            head_load = 1'b1;
        end
    end

    // Registered head-of-queue outputs; they keep the last command when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jdo    <= '0;
            cmd_ir <= '0;
        end else if (head_load) begin
            {cmd_ir, jdo} <= head_nxt;
        end
    end

    // One-cycle decode strobes for the command being popped this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= (pop &&  jdo[ACT_BIT]) ? onehot(cmd_ir) : '0;
            take_no_action <= (pop && !jdo[ACT_BIT]) ? onehot(cmd_ir) : '0;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nios_cpu_debug_cmd_sysclk.sv
// Directed bench for nios_cpu_debug_cmd_sysclk with default parameters.
module tb_nios_cpu_debug_cmd_sysclk;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] sr;
    logic [1:0]  ir_in;
    logic        vs_udr;
    logic        vs_uir;
    logic        cmd_ready;
    logic        ovf_clr;
    logic [37:0] jdo;
    logic [1:0]  cmd_ir;
    logic        cmd_valid;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic        ir_update;
    logic [2:0]  fifo_level;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    nios_cpu_debug_cmd_sysclk dut (
        .clk            (clk),
        .reset          (reset),
        .sr             (sr),
        .ir_in          (ir_in),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .cmd_ready      (cmd_ready),
        .ovf_clr        (ovf_clr),
        .jdo            (jdo),
        .cmd_ir         (cmd_ir),
        .cmd_valid      (cmd_valid),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .ir_update      (ir_update),
        .fifo_level     (fifo_level),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Entry pattern: bit 34 (action select) follows the low bit of i.
    function automatic logic [37:0] v(input int i);
        logic [31:0] lo;
        lo = 32'hA5A5_0000 + i;
        return {3'b000, lo[0], 2'b00, lo};
    endfunction

    // One clock: active edge, then settle to the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_pulse(input logic [1:0] ir, input logic [37:0] d);
        ir_in  = ir;
        sr     = d;
        vs_udr = 1'b1;
        repeat (6) cyc();
        vs_udr = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        cyc();
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        total++;
        if ({jdo, cmd_ir, cmd_valid, take_action, take_no_action, ir_update, fifo_level, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got jdo=%h ir=%h v=%b ta=%b tna=%b iru=%b lvl=%0d ovf=%b want all zero",
                     jdo, cmd_ir, cmd_valid, take_action, take_no_action, ir_update, fifo_level, overflow);
        end
        reset = 1'b0;
        repeat (2) cyc();
        total++;
        if (cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin
            bad++;
            $display("FAIL reset_release: got valid=%b lvl=%0d want 0/0", cmd_valid, fifo_level);
        end
    endtask

    task automatic test_latency();
        ir_in  = 2'd1;
        sr     = 38'h4_0000_00AB;
        vs_udr = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k == 3) begin
                total++;
                if (cmd_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL latency_edge3: got valid=%b want 0", cmd_valid);
                end
            end
            if (k == 4) begin
                total++;
                if (cmd_valid !== 1'b1 || jdo !== 38'h4_0000_00AB || cmd_ir !== 2'd1 || fifo_level !== 3'd1) begin
                    bad++;
                    $display("FAIL latency_edge4: got valid=%b jdo=%h ir=%0d lvl=%0d want 1/40000000ab/1/1",
                             cmd_valid, jdo, cmd_ir, fifo_level);
                end
            end
        end
        vs_udr = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_decode();
        total++;
        if (take_action !== 4'b0000 || take_no_action !== 4'b0000) begin
            bad++;
            $display("FAIL decode_idle: got ta=%b tna=%b want 0/0", take_action, take_no_action);
        end
        pop_one();
        total++;
        if (take_action !== 4'b0010 || take_no_action !== 4'b0000 || cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin
            bad++;
            $display("FAIL decode_strobe: got ta=%b tna=%b valid=%b lvl=%0d want 0010/0000/0/0",
                     take_action, take_no_action, cmd_valid, fifo_level);
        end
        cyc();
        total++;
        if (take_action !== 4'b0000 || jdo !== 38'h4_0000_00AB) begin
            bad++;
            $display("FAIL decode_after: got ta=%b jdo=%h want 0000/40000000ab", take_action, jdo);
        end
    endtask

    task automatic test_no_action();
        push_pulse(2'd3, 38'h0_1234_5678);
        pop_one();
        total++;
        if (take_no_action !== 4'b1000 || take_action !== 4'b0000) begin
            bad++;
            $display("FAIL no_action_strobe: got tna=%b ta=%b want 1000/0000", take_no_action, take_action);
        end
        cyc();
        total++;
        if (take_no_action !== 4'b0000 || take_action !== 4'b0000) begin
            bad++;
            $display("FAIL no_action_one_cycle: got tna=%b ta=%b want 0/0", take_no_action, take_action);
        end
    endtask

    task automatic test_empty_ready();
        cmd_ready = 1'b1;
        ir_in     = 2'd2;
        sr        = 38'h4_0000_0CAB;
        vs_udr    = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k == 2) begin
                total++;
                if (take_action !== 4'b0000 || take_no_action !== 4'b0000 || fifo_level !== 3'd0) begin
                    bad++;
                    $display("FAIL ready_when_empty: got ta=%b tna=%b lvl=%0d want 0/0/0",
                             take_action, take_no_action, fifo_level);
                end
            end
            if (k == 4) begin
                total++;
                if (fifo_level !== 3'd1 || take_action !== 4'b0000) begin
                    bad++;
                    $display("FAIL empty_push_ready: got lvl=%0d ta=%b want 1/0000", fifo_level, take_action);
                end
            end
            if (k == 5) begin
                total++;
                if (fifo_level !== 3'd0 || take_action !== 4'b0100) begin
                    bad++;
                    $display("FAIL empty_push_then_pop: got lvl=%0d ta=%b want 0/0100", fifo_level, take_action);
                end
            end
        end
        vs_udr    = 1'b0;
        cmd_ready = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_overflow();
        logic [3:0] exp_oh;
        for (int i = 0; i < 5; i++) push_pulse(i[1:0], v(i));
        total++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_set: got lvl=%0d ovf=%b want 4/1", fifo_level, overflow);
        end
        // Clear held across a further dropped push: clear then set on the drop edge.
        ir_in   = 2'd0;
        sr      = 38'h3F_FFFF_FFFF;
        vs_udr  = 1'b1;
        ovf_clr = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k == 3) begin
                total++;
                if (overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_clr: got ovf=%b want 0", overflow);
                end
            end
            if (k == 4) begin
                ovf_clr = 1'b0;
                total++;
                if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
                    bad++;
                    $display("FAIL ovf_set_wins: got ovf=%b lvl=%0d want 1/4", overflow, fifo_level);
                end
            end
        end
        vs_udr = 1'b0;
        repeat (4) cyc();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (jdo !== v(i) || cmd_ir !== i[1:0] || cmd_valid !== 1'b1) begin
                bad++;
                $display("FAIL overflow_order[%0d]: got jdo=%h ir=%0d valid=%b want %h/%0d/1",
                         i, jdo, cmd_ir, cmd_valid, v(i), i[1:0]);
            end
            pop_one();
            exp_oh       = '0;
            exp_oh[i % 4] = 1'b1;
            total++;
            if (take_action !== (i[0] ? exp_oh : 4'b0000) || take_no_action !== (i[0] ? 4'b0000 : exp_oh)) begin
                bad++;
                $display("FAIL overflow_strobe[%0d]: got ta=%b tna=%b want onehot %b act=%b",
                         i, take_action, take_no_action, exp_oh, i[0]);
            end
        end
        total++;
        if (fifo_level !== 3'd0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_drained: got lvl=%0d ovf=%b want 0/1", fifo_level, overflow);
        end
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow_clear: got ovf=%b want 0", overflow);
        end
    endtask

    task automatic test_full_bypass();
        for (int i = 10; i < 14; i++) push_pulse(i[1:0], v(i));
        total++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL bypass_full: got lvl=%0d ovf=%b want 4/0", fifo_level, overflow);
        end
        ir_in  = 2'd2;
        sr     = v(14);
        vs_udr = 1'b1;
        repeat (3) cyc();
        cmd_ready = 1'b1;
        cyc();
        cmd_ready = 1'b0;
        total++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0 || take_no_action !== 4'b0100 || take_action !== 4'b0000) begin
            bad++;
            $display("FAIL bypass_same_cycle: got lvl=%0d ovf=%b tna=%b ta=%b want 4/0/0100/0000",
                     fifo_level, overflow, take_no_action, take_action);
        end
        repeat (2) cyc();
        vs_udr = 1'b0;
        repeat (4) cyc();
        for (int i = 11; i < 15; i++) begin
            total++;
            if (jdo !== v(i) || cmd_ir !== i[1:0]) begin
                bad++;
                $display("FAIL bypass_order[%0d]: got jdo=%h ir=%0d want %h/%0d", i, jdo, cmd_ir, v(i), i[1:0]);
            end
            pop_one();
        end
        total++;
        if (fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL bypass_drained: got lvl=%0d valid=%b want 0/0", fifo_level, cmd_valid);
        end
    endtask

    task automatic test_ir_update();
        int cnt;
        cnt    = 0;
        vs_uir = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 6) vs_uir = 1'b0;
            if (k == 3) begin
                total++;
                if (ir_update !== 1'b1) begin
                    bad++;
                    $display("FAIL ir_update_timing: got %b want 1", ir_update);
                end
            end
            if (ir_update === 1'b1) cnt++;
        end
        total++;
        if (cnt != 1 || fifo_level !== 3'd0) begin
            bad++;
            $display("FAIL ir_update_single: got pulses=%0d lvl=%0d want 1/0", cnt, fifo_level);
        end
    endtask

    task automatic test_reset_mid();
        int strobe_seen;
        strobe_seen = 0;
        for (int i = 20; i < 23; i++) push_pulse(i[1:0], v(i));
        total++;
        if (fifo_level !== 3'd3) begin
            bad++;
            $display("FAIL reset_mid_fill: got lvl=%0d want 3", fifo_level);
        end
        ir_in  = 2'd3;
        sr     = v(23);
        vs_udr = 1'b1;
        repeat (2) cyc();
        reset = 1'b1;
        #1;
        total++;
        if ({jdo, cmd_ir, cmd_valid, take_action, take_no_action, ir_update, fifo_level, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_mid_async: got jdo=%h ir=%h v=%b ta=%b tna=%b lvl=%0d want all zero",
                     jdo, cmd_ir, cmd_valid, take_action, take_no_action, fifo_level);
        end
        repeat (2) cyc();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (take_action !== 4'b0000 || take_no_action !== 4'b0000) strobe_seen++;
            if (k == 3) begin
                total++;
                if (fifo_level !== 3'd0) begin
                    bad++;
                    $display("FAIL reset_mid_early: got lvl=%0d want 0", fifo_level);
                end
            end
        end
        total++;
        if (strobe_seen != 0) begin
            bad++;
            $display("FAIL reset_mid_no_strobe: got %0d strobe cycles want 0", strobe_seen);
        end
        vs_udr = 1'b0;
        repeat (4) cyc();
        total++;
        if (fifo_level !== 3'd1 || jdo !== v(23) || cmd_ir !== 2'd3) begin
            bad++;
            $display("FAIL reset_mid_one_entry: got lvl=%0d jdo=%h ir=%0d want 1/%h/3", fifo_level, jdo, cmd_ir, v(23));
        end
        pop_one();
        total++;
        if (take_action !== 4'b1000 || take_no_action !== 4'b0000 || fifo_level !== 3'd0) begin
            bad++;
            $display("FAIL reset_mid_pop: got ta=%b tna=%b lvl=%0d want 1000/0000/0",
                     take_action, take_no_action, fifo_level);
        end
    endtask

    initial begin
        reset     = 1'b1;
        sr        = '0;
        ir_in     = '0;
        vs_udr    = 1'b0;
        vs_uir    = 1'b0;
        cmd_ready = 1'b0;
        ovf_clr   = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_decode();
        test_no_action();
        test_empty_ready();
        test_overflow();
        test_full_bypass();
        test_ir_update();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
